hs32_fetch: RTL

HS32_FETCH -- requirements
Module: hs32_fetch

---
 rtl/hs32_fetch_pkg.sv | 20 ++
 rtl/hs32_fetch_fifo.sv | 54 +++++
 rtl/hs32_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/hs32_fetch_pkg.sv
// Shared constants and types for the hs32 instruction fetch unit.
package hs32_fetch_pkg;
    localparam int INST_W = 32;
    localparam int ENT_W = 2 * INST_W;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [INST_W-1:0] PC_INC = 32'd4;
    localparam logic [INST_W-1:0] RESET_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    function automatic logic [INST_W-1:0] align_pc(input logic [INST_W-1:0] a);
        return {a[INST_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/hs32_fetch_fifo.sv
// Two-entry prefetch buffer of {addr, data} words; head is the oldest entry.
module hs32_fetch_fifo
    import hs32_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [ENT_W-1:0] din,
    output logic [ENT_W-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [ENT_W-1:0] e0, e1;
    logic             pop_ok;

    assign head   = e0;
    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            e0    <= '0;
            e1    <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == '0)
                        e0 <= din;
                    else
                        e1 <= din;
                    if (count != BUF_FULL)
                        count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop: count unchanged, older entry leaves first.
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/hs32_fetch.sv
// Instruction fetch: one outstanding memory read, 2-deep prefetch, redirect on flush.
module hs32_fetch
    import hs32_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] newpc,
    input  logic              flush,
    output logic [INST_W-1:0] addr,
    output logic              reqm,
    input  logic              ackm,
    input  logic [INST_W-1:0] dtrm,
    input  logic              reqd,
    output logic              ackd,
    output logic [INST_W-1:0] instd,
    output logic [INST_W-1:0] pcd
);
    state_t            state, state_n;
    logic [INST_W-1:0] pc, pc_n, tgt, tgt_n, addr_n;
    logic              reqm_n, push, pop;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  count;

    assign pop = reqd && (count != '0) && !ackd && !flush;

    hs32_fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   ({addr, dtrm}),
        .head  (head),
        .count (count)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        tgt_n   = tgt;
        addr_n  = addr;
        reqm_n  = reqm;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    pc_n = align_pc(newpc);
                end else if (count != BUF_FULL) begin
                    state_n = WAIT;
                    reqm_n  = 1'b1;
                    addr_n  = pc;
                end
            end
            WAIT: begin
                if (flush && ackm) begin
                    pc_n    = align_pc(newpc);
                    state_n = IDLE;
                    reqm_n  = 1'b0;
                end else if (flush) begin
                    // Bus read cannot be aborted; ride it out in DISCARD.
                    tgt_n   = align_pc(newpc);
                    state_n = DISCARD;
                end else if (ackm) begin
                    push    = 1'b1;
                    pc_n    = pc + PC_INC;
                    state_n = IDLE;
                    reqm_n  = 1'b0;
                end
            end
            DISCARD: begin
                if (flush)
                    tgt_n = align_pc(newpc);
                if (ackm) begin
                    pc_n    = flush ? align_pc(newpc) : tgt;
                    state_n = IDLE;
                    reqm_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_VEC;
            tgt   <= '0;
            reqm  <= 1'b0;
            addr  <= '0;
            ackd  <= 1'b0;
            instd <= '0;
            pcd   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            tgt   <= tgt_n;
            reqm  <= reqm_n;
            addr  <= addr_n;
            ackd  <= pop;
            if (pop) begin
                pcd   <= head[ENT_W-1:INST_W];
                instd <= head[INST_W-1:0];
            end
        end
    end
endmodule
